br_tracker_freelist: RTL and testbench

// - Allocates unique binary entry IDs from a pool of NumEntries and reclaims them on deallocation.
// - Sits directly upstream of the binary-to-onehot encoder: the encoder decodes the allocated

---
 rtl/br_enc_priority_encoder.sv | 25 ++
 rtl/br_tracker_freelist.sv | 118 +++++++++++
 tb/tb_br_tracker_freelist.sv | 191 +++++++++++++++++++
 3 files changed

// File: rtl/br_enc_priority_encoder.sv
// Lowest-set-bit priority encoder: reports whether any request bit is set and
// the binary index of the lowest one.
module br_enc_priority_encoder #(
    parameter  int NumRequesters = 2,
    localparam int IdxWidth      = $clog2(NumRequesters)
) (
    input  logic [NumRequesters-1:0] in,
    output logic                     out_valid,
    output logic [IdxWidth-1:0]      out_idx
);

    always_comb begin
        // NOTE: combinational logic uses blocking assignments with every output
        // defaulted first, so no path can hold a stale value and infer a latch.
        out_valid = |in;
        out_idx   = '0;
        // Scan downward so the lowest set index is the last (winning) write.
        for (int i = NumRequesters - 1; i >= 0; i--) begin
            if (in[i]) begin
                out_idx = IdxWidth'(i);
            end
        end
    end

endmodule

// File: rtl/br_tracker_freelist.sv
// Free-list tracker: hands out unique binary entry IDs lowest-index-first through
// a registered ready/valid stage and reclaims them on deallocation.
module br_tracker_freelist #(
    parameter  int NumEntries = 2,
    localparam int IdWidth    = $clog2(NumEntries),
    localparam int CountWidth = $clog2(NumEntries + 1)
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  alloc_ready,
    output logic                  alloc_valid,
    output logic [IdWidth-1:0]    alloc_entry_id,
    input  logic                  dealloc_valid,
    input  logic [IdWidth-1:0]    dealloc_entry_id,
    output logic [CountWidth-1:0] free_count
);

    if (NumEntries < 2) begin : g_bad_param
        $error("br_tracker_freelist: NumEntries must be >= 2");
    end

    logic [NumEntries-1:0] free_q, free_d;
    logic                  stage_valid_q, stage_valid_d;
    logic [IdWidth-1:0]    stage_id_q, stage_id_d;
    logic [CountWidth-1:0] count_q, count_d;

    logic               enc_valid;
    logic [IdWidth-1:0] enc_idx;
    logic               accept;
    logic               load;

    br_enc_priority_encoder #(
        .NumRequesters(NumEntries)
    ) u_prio_enc (
        .in       (free_q),
        .out_valid(enc_valid),
        .out_idx  (enc_idx)
    );

    assign accept = stage_valid_q && alloc_ready;
    assign load   = !stage_valid_q || accept;

    always_comb begin
        free_d        = free_q;
        stage_valid_d = stage_valid_q;
        stage_id_d    = stage_id_q;
        count_d       = count_q;

        // The encoder sees the pre-dealloc free_q, so a returned ID is never
        // staged on the edge that frees it.
        if (load) begin
            if (enc_valid) begin
                stage_valid_d   = 1'b1;
                stage_id_d      = enc_idx;
                free_d[enc_idx] = 1'b0;
            end else begin
                stage_valid_d = 1'b0;
            end
        end

        if (dealloc_valid && (int'(dealloc_entry_id) < NumEntries)) begin
            free_d[dealloc_entry_id] = 1'b1;
        end

        if (accept && !dealloc_valid) begin
            count_d = count_q - CountWidth'(1);
        end else if (!accept && dealloc_valid) begin
            count_d = count_q + CountWidth'(1);
        end
    end

    always_ff @(posedge clk) begin
        // NOTE: state flops use non-blocking assignments so every flop samples
        // its pre-edge inputs regardless of statement order.
        if (rst) begin
            // NOTE: free_q is a small bit-vector of flops, not a RAM, so resetting
            // it to all-free is cheap and required for correct restart.
            free_q        <= '1;
            stage_valid_q <= 1'b0;
            stage_id_q    <= '0;
            count_q       <= CountWidth'(NumEntries);
        end else begin
            free_q        <= free_d;
            stage_valid_q <= stage_valid_d;
            stage_id_q    <= stage_id_d;
            count_q       <= count_d;
        end
    end

    assign alloc_valid    = stage_valid_q;
    assign alloc_entry_id = stage_id_q;
    assign free_count     = count_q;

    // Integration and internal consistency checks (simulation only).
    always_ff @(posedge clk) begin
        if (!rst) begin
            if (dealloc_valid) begin
                assert (int'(dealloc_entry_id) < NumEntries)
                    else $error("dealloc_entry_id out of range");
                assert (!free_q[dealloc_entry_id])
                    else $error("dealloc of an already-free ID");
                assert (!(stage_valid_q && (stage_id_q == dealloc_entry_id)))
                    else $error("dealloc of the staged ID");
            end
            assert (!(stage_valid_q && free_q[stage_id_q]))
                else $error("staged ID still marked free");
            assert (count_q == CountWidth'($countones(free_q)) + CountWidth'(stage_valid_q))
                else $error("count_q inconsistent with free_q and stage");
            assert (!stage_valid_q || (int'(stage_id_q) < NumEntries))
                else $error("staged ID out of range");
        end
    end

    a_hold_stable: assert property (@(posedge clk) disable iff (rst)
        (alloc_valid && !alloc_ready) |=> (alloc_valid && $stable(alloc_entry_id)))
        else $error("alloc offer changed or dropped without acceptance");

endmodule

// File: tb/tb_br_tracker_freelist.sv
// Directed bench for br_tracker_freelist (4 entries) plus a randomized
// alloc/dealloc run on a 5-entry instance with a small outstanding-ID model.
module tb_br_tracker_freelist;

    logic       clk = 1'b0;
    logic       rst;
    logic       alloc_ready;
    logic       alloc_valid;
    logic [1:0] alloc_entry_id;
    logic       dealloc_valid;
    logic [1:0] dealloc_entry_id;
    logic [2:0] free_count;

    logic       rst5;
    logic       alloc_ready5;
    logic       alloc_valid5;
    logic [2:0] alloc_entry_id5;
    logic       dealloc_valid5;
    logic [2:0] dealloc_entry_id5;
    logic [2:0] free_count5;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    br_tracker_freelist #(.NumEntries(4)) dut (
        .clk             (clk),
        .rst             (rst),
        .alloc_ready     (alloc_ready),
        .alloc_valid     (alloc_valid),
        .alloc_entry_id  (alloc_entry_id),
        .dealloc_valid   (dealloc_valid),
        .dealloc_entry_id(dealloc_entry_id),
        .free_count      (free_count)
    );

    br_tracker_freelist #(.NumEntries(5)) dut5 (
        .clk             (clk),
        .rst             (rst5),
        .alloc_ready     (alloc_ready5),
        .alloc_valid     (alloc_valid5),
        .alloc_entry_id  (alloc_entry_id5),
        .dealloc_valid   (dealloc_valid5),
        .dealloc_entry_id(dealloc_entry_id5),
        .free_count      (free_count5)
    );

    task automatic check(input string tag, input int got, input int exp);
        checks++;
        if (got != exp) begin
            errors++;
            $display("FAIL %s got %0d expected %0d", tag, got, exp);
        end
    endtask

    // Advance one clock; inputs are driven and outputs sampled 1ns after the edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset(input logic ready);
        rst           = 1'b1;
        alloc_ready   = ready;
        dealloc_valid = 1'b0;
        dealloc_entry_id = '0;
        step();
        step();
        check("rst_valid", int'(alloc_valid), 0);
        check("rst_count", int'(free_count), 4);
        rst = 1'b0;
        step();
    endtask

    initial begin
        logic [4:0] outstanding;
        logic       acc;
        logic [2:0] acc_id;
        logic       hold;
        logic [2:0] hold_id;
        int         pick;

        rst5              = 1'b1;
        alloc_ready5      = 1'b0;
        dealloc_valid5    = 1'b0;
        dealloc_entry_id5 = '0;

        // Reset release with ready held: IDs 0..3 on consecutive cycles.
        do_reset(1'b1);
        for (int i = 0; i < 4; i++) begin
            check("burst_valid", int'(alloc_valid), 1);
            check("burst_id", int'(alloc_entry_id), i);
            check("burst_count", int'(free_count), 4 - i);
            step();
        end
        check("exhaust_valid", int'(alloc_valid), 0);
        check("exhaust_count", int'(free_count), 0);

        // Empty pool, dealloc ID 2 at cycle t.
        dealloc_valid    = 1'b1;
        dealloc_entry_id = 2'd2;
        step();
        dealloc_valid = 1'b0;
        check("dealloc_t1_count", int'(free_count), 1);
        check("dealloc_t1_valid", int'(alloc_valid), 0);
        step();
        check("dealloc_t2_valid", int'(alloc_valid), 1);
        check("dealloc_t2_id", int'(alloc_entry_id), 2);
        check("dealloc_t2_count", int'(free_count), 1);

        // Backpressure after reset.
        do_reset(1'b0);
        for (int i = 0; i < 5; i++) begin
            check("bp_valid", int'(alloc_valid), 1);
            check("bp_id", int'(alloc_entry_id), 0);
            check("bp_count", int'(free_count), 4);
            step();
        end

        // Simultaneous accept of staged ID 2 and dealloc of ID 0.
        alloc_ready = 1'b1;
        step();
        step();
        check("sim_pre_id", int'(alloc_entry_id), 2);
        check("sim_pre_count", int'(free_count), 2);
        dealloc_valid    = 1'b1;
        dealloc_entry_id = 2'd0;
        step();
        dealloc_valid = 1'b0;
        check("sim_valid", int'(alloc_valid), 1);
        check("sim_id", int'(alloc_entry_id), 3);
        check("sim_count", int'(free_count), 2);
        step();
        check("sim_next_id", int'(alloc_entry_id), 0);
        check("sim_next_count", int'(free_count), 1);

        // Mid-operation reset after 3 allocations.
        do_reset(1'b1);
        step();
        step();
        step();
        check("mid_pre_id", int'(alloc_entry_id), 3);
        check("mid_pre_count", int'(free_count), 1);
        alloc_ready = 1'b0;
        rst         = 1'b1;
        step();
        check("mid_rst_valid", int'(alloc_valid), 0);
        check("mid_rst_count", int'(free_count), 4);
        rst = 1'b0;
        step();
        check("mid_post_valid", int'(alloc_valid), 1);
        check("mid_post_id", int'(alloc_entry_id), 0);
        check("mid_post_count", int'(free_count), 4);

        // Randomized run on the 5-entry instance.
        rst5 = 1'b0;
        step();
        outstanding = '0;
        hold        = 1'b0;
        hold_id     = '0;
        for (int cyc = 0; cyc < 3000; cyc++) begin
            check("rnd_count", int'(free_count5), 5 - $countones(outstanding));
            if (hold) begin
                check("rnd_hold_valid", int'(alloc_valid5), 1);
                check("rnd_hold_id", int'(alloc_entry_id5), int'(hold_id));
            end
            alloc_ready5 = ($urandom_range(0, 3) != 0);
            pick = int'($urandom_range(0, 4));
            dealloc_valid5    = outstanding[pick] && ($urandom_range(0, 2) == 0);
            dealloc_entry_id5 = 3'(pick);
            acc    = alloc_valid5 && alloc_ready5;
            acc_id = alloc_entry_id5;
            hold    = alloc_valid5 && !alloc_ready5;
            hold_id = alloc_entry_id5;
            if (acc) begin
                check("rnd_id_range", int'(acc_id < 3'd5), 1);
                check("rnd_unique", int'(outstanding[acc_id]), 0);
            end
            step();
            if (dealloc_valid5) outstanding[pick] = 1'b0;
            if (acc && acc_id < 3'd5) outstanding[acc_id] = 1'b1;
        end
        alloc_ready5   = 1'b0;
        dealloc_valid5 = 1'b0;

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
